// File: rtl/wheel_arbiter.sv
// wheel_arbiter
//
// Shares one 2-bit wheel-drive output between three command sources using
// round-robin priority. A grant lasts at least HOLD and at most TIMEOUT
// cycles; an emergency stop zeroes the drive immediately and holds it there.
//
// Ports
//   clk         single clock, all state changes on posedge
//   rst         synchronous active-low reset
//   req[2:0]    request per source, req[i] belongs to source i
//   cmd0..cmd2  wheel command per source (11 both, 01 right, 10 left, 00 stop)
//   estop       level-sensitive emergency stop
//   gnt[2:0]    one-hot grant, 000 when no owner
//   z[1:0]      wheel drive to the motor stage
//   busy        high while a grant is active
//   timeout     one-cycle pulse when a grant is ended by TIMEOUT
//
// State | meaning
// ------+----------------------------------------------
// IDLE  | no owner; arbitrates among pending requests
// GRANT | one owner (owner_q) drives z
// STOP  | emergency stop active, outputs forced to zero

module wheel_arbiter #(
    parameter int HOLD    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [1:0] cmd0,
    input  logic [1:0] cmd1,
    input  logic [1:0] cmd2,
    input  logic       estop,
    output logic [2:0] gnt,
    output logic [1:0] z,
    output logic       busy,
    output logic       timeout
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_STOP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [1:0]      z_q, z_d;
    logic            timeout_q, timeout_d;

    logic [1:0]      cand1, cand2, cand3;
    logic [1:0]      win;
    logic            owner_req;
    logic [1:0]      owner_cmd;
    logic            at_timeout;
    logic            hold_met;

    // Source index following s in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    function automatic logic req_of(input logic [2:0] r, input logic [1:0] s);
        case (s)
            2'd0:    return r[0];
            2'd1:    return r[1];
            default: return r[2];
        endcase
    endfunction

    function automatic logic [1:0] cmd_of(input logic [1:0] s,
                                          input logic [1:0] c0,
                                          input logic [1:0] c1,
                                          input logic [1:0] c2);
        case (s)
            2'd0:    return c0;
            2'd1:    return c1;
            default: return c2;
        endcase
    endfunction

    // Round-robin scan starting just after the last released owner. When no
    // request is pending win is unused, so the fall-through value is harmless.
    always_comb begin
        cand1 = next_src(last_q);
        cand2 = next_src(cand1);
        cand3 = next_src(cand2);
        if (req_of(req, cand1)) begin
            win = cand1;
        end else if (req_of(req, cand2)) begin
            win = cand2;
        end else begin
            win = cand3;
        end
    end

    always_comb begin
        owner_req  = req_of(req, owner_q);
        owner_cmd  = cmd_of(owner_q, cmd0, cmd1, cmd2);
        at_timeout = (cnt_q == CW'(TIMEOUT));
        hold_met   = (cnt_q >= CW'(HOLD));
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        z_d       = z_q;
        timeout_d = 1'b0;

        // Emergency stop wins from any state; last_q is deliberately kept so
        // an interrupted owner keeps its place in the rotation.
        if (estop) begin
            state_d = S_STOP;
            gnt_d   = 3'b000;
            z_d     = 2'b00;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_STOP: begin
                    state_d = S_IDLE;
                    gnt_d   = 3'b000;
                    z_d     = 2'b00;
                end

                S_IDLE: begin
                    gnt_d = 3'b000;
                    z_d   = 2'b00;
                    if (|req) begin
                        state_d = S_GRANT;
                        owner_d = win;
                        gnt_d   = 3'b001 << win;
                        z_d     = cmd_of(win, cmd0, cmd1, cmd2);
                        cnt_d   = CW'(1);
                    end
                end

                S_GRANT: begin
                    // TIMEOUT is tested first so a simultaneous HOLD release
                    // still reports the timeout pulse.
                    if (at_timeout || (hold_met && !owner_req)) begin
                        state_d   = S_IDLE;
                        gnt_d     = 3'b000;
                        z_d       = 2'b00;
                        last_d    = owner_q;
                        timeout_d = at_timeout;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        // Owner dropped its request before HOLD: keep driving
                        // its last command until the minimum hold expires.
                        if (owner_req) begin
                            z_d = owner_cmd;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    gnt_d   = 3'b000;
                    z_d     = 2'b00;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 2'd0;
            last_q    <= 2'd2;
            cnt_q     <= '0;
            gnt_q     <= 3'b000;
            z_q       <= 2'b00;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            z_q       <= z_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign z       = z_q;
    assign busy    = (state_q == S_GRANT);
    assign timeout = timeout_q;

endmodule
